// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Bit count never drops to zero, so WIDTH=1 still gets a 1-bit counter.
  function automatic int cnt_w(int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only datapath child of serial_add_ctrl.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder reused over WIDTH cycles, LSB first, valid/ready on both sides.
// Define SERIAL_ADD_SUB_EN to add a 'sub' input selecting a - b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CntW = cnt_w(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  if (WIDTH < 1) begin : g_width_check
    $error("serial_add_ctrl: WIDTH must be >= 1");
  end

  state_t           r_state;
  state_t           w_state_d;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;

  logic             w_accept;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_b_load;
  logic             w_carry_load;

  assign w_accept = in_valid && (r_state == S_IDLE);

  // Subtract is a + ~b + 1; cout then reads as "no borrow".
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_load     = sub ? ~b : b;
  assign w_carry_load = sub ? 1'b1 : cin;
`else
  assign w_b_load     = b;
  assign w_carry_load = cin;
`endif

  full_adder u_full_adder (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_c)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_d = S_RUN;
      S_RUN:   if (r_cnt == CntLast) w_state_d = S_DONE;
      S_DONE:  if (out_ready) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Shift-based update keeps WIDTH=1 legal (no [WIDTH-1:1] slice).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= w_b_load;
      r_carry <= w_carry_load;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= (r_sum_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
      r_carry  <= w_c;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum_sh;
  assign cout      = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=4): directed cases, reset abort, random ops.
module tb_serial_add_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on WIDTH+1 bits.
  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] ra,
                                                input logic [WIDTH-1:0] rb,
                                                input logic rcin, input logic rsub);
    int unsigned total;
    int unsigned mask;
    mask = (1 << WIDTH) - 1;
    if (rsub) total = int'(ra) + ((~int'(rb)) & mask) + 1;
    else      total = int'(ra) + int'(rb) + int'(rcin);
    return total[WIDTH:0];
  endfunction

  task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                       input logic ocin, input logic osub, input int hold);
    logic [WIDTH:0] exp;
    int lat;
    exp = ref_result(oa, ob, ocin, osub);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom;
    check("busy_run", 32'(busy), 32'd1);
    check("in_ready_run", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < WIDTH + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(WIDTH));
    check("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
    check("cout", 32'(cout), 32'(exp[WIDTH]));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(exp[WIDTH-1:0]));
      check("hold_cout", 32'(cout), 32'(exp[WIDTH]));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;

    do_op(4'h3, 4'h5, 1'b0, 1'b0, 0);
    do_op(4'hF, 4'h1, 1'b0, 1'b0, 0);
    do_op(4'hF, 4'hF, 1'b1, 1'b0, 1);
    do_op(4'h1, 4'h1, 1'b0, 1'b0, 3);

    // Abort an op during its second RUN cycle.
    a = 4'h7; b = 4'h6; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(4'h2, 4'h2, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
    do_op(4'h5, 4'h3, 1'b0, 1'b1, 0);
    do_op(4'h3, 4'h5, 1'b1, 1'b1, 0);
`endif

    for (int k = 0; k < 24; k++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic rc;
      logic rs;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rc, rs, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
